// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line levels and default widths
// used by both the TX and RX sides.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_DIV_WIDTH  = 16;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: loaded at frame start, ticks on reaching zero and
// reloads, so every bit lasts reload_val+1 clocks. Held at reload while not running.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    input  logic [DIV_WIDTH-1:0] reload_val,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    assign tick = run & (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!run || cnt == '0) begin
            cnt <= reload_val;
        end else begin
            cnt <= cnt - DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer draining the TX FIFO through its combinational pop
// handshake. Optional parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  stop2,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_en,
    input  logic                  parity_odd,
`endif
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_r_en,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done,
    output uart_state_t           state_dbg
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BCW-1:0]        bit_cnt;
    logic [DIV_WIDTH-1:0]  div_lat;
    logic                  stop2_lat;
    logic                  stop_cnt;
    logic                  tick;
    logic                  last_stop_tick;
    logic                  pop;
`ifdef UART_TX_PARITY_EN
    logic                  par_en_lat;
    logic                  par_bit;
`endif

    assign last_stop_tick = (state == ST_STOP) & tick & (stop_cnt == stop2_lat);

    // Gated by rst_n so no pop is offered while reset holds the FSM in IDLE.
    assign pop = rst_n & tx_en & ~fifo_empty & ((state == ST_IDLE) | last_stop_tick);

    assign fifo_r_en = pop;
    assign busy      = (state != ST_IDLE);
    assign tx_done   = last_stop_tick;
    assign state_dbg = state;

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state != ST_IDLE),
        .load       (pop),
        .load_val   (baud_div),
        .reload_val (div_lat),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_lat   <= '0;
            stop2_lat <= 1'b0;
            stop_cnt  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_lat <= 1'b0;
            par_bit    <= 1'b0;
`endif
        end else if (pop) begin
            // Pop edge: capture word and per-frame settings, start the start bit.
            state     <= ST_START;
            shift_reg <= fifo_r_data;
            div_lat   <= baud_div;
            stop2_lat <= stop2;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_lat <= parity_en;
            par_bit    <= (^fifo_r_data) ^ parity_odd;
`endif
        end else if (tick) begin
            case (state)
                ST_START: begin
                    state   <= ST_DATA;
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                        stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        state <= par_en_lat ? ST_PARITY : ST_STOP;
`else
                        state <= ST_STOP;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    state    <= ST_STOP;
                    stop_cnt <= 1'b0;
                end
`endif
                ST_STOP: begin
                    if (stop_cnt == stop2_lat) begin
                        state <= ST_IDLE;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        txd = UART_IDLE_LEVEL;
        case (state)
            ST_START: txd = UART_START_LEVEL;
            ST_DATA:  txd = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd = par_bit;
`endif
            default:  txd = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine; parity scenarios run when UART_TX_PARITY_EN is defined.
module tb_uart_tx_engine;
    import uart_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        tx_en;
    logic [15:0] baud_div;
    logic        stop2;
    logic        parity_en;
    logic        parity_odd;
    logic        fifo_empty;
    logic [7:0]  fifo_r_data;
    logic        fifo_r_en;
    logic        txd;
    logic        busy;
    logic        tx_done;
    uart_state_t state_dbg;

    int checks = 0;
    int errors = 0;

    logic [7:0]   fifo_q[$];
    logic         pop_pending;
    logic [127:0] cap_txd, cap_ren, cap_done, cap_busy;
    logic [127:0] exp_v;

    uart_tx_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_en       (tx_en),
        .baud_div    (baud_div),
        .stop2       (stop2),
`ifdef UART_TX_PARITY_EN
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
`endif
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_r_en   (fifo_r_en),
        .txd         (txd),
        .busy        (busy),
        .tx_done     (tx_done),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // FIFO model: pop decision sampled just before the edge, queue updated just after
    task automatic update_fifo();
        fifo_empty  = (fifo_q.size() == 0);
        fifo_r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    always @(negedge clk) begin
        #4;
        pop_pending = fifo_r_en;
    end

    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
        pop_pending = 1'b0;
        update_fifo();
    end

    // drivers
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        update_fifo();
    endtask

    // evt_code 1: drop tx_en; 2: change baud_div/stop2 mid-frame
    task automatic capture(input int n, input int evt_k, input int evt_code);
        cap_txd  = '1;
        cap_ren  = '0;
        cap_done = '0;
        cap_busy = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_txd[k]  = txd;
            cap_ren[k]  = fifo_r_en;
            cap_done[k] = tx_done;
            cap_busy[k] = busy;
            if (k == evt_k && evt_code == 1) tx_en = 1'b0;
            if (k == evt_k && evt_code == 2) begin
                baud_div = 16'd0;
                stop2    = 1'b0;
            end
        end
    endtask

    // expected txd: idle-high outside the frame, levels string in time order
    function automatic logic [127:0] wave(input string lv, input int per, input int start);
        logic [127:0] v;
        v = '1;
        for (int i = 0; i < lv.len(); i++)
            for (int j = 0; j < per; j++)
                v[start + i * per + j] = (lv[i] == "1");
        return v;
    endfunction

    function automatic logic [127:0] span(input int lo, input int hi);
        logic [127:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; tx_en = 1'b0; baud_div = 16'd0; stop2 = 1'b0;
        parity_en = 1'b0; parity_odd = 1'b0;
        fifo_q.delete();
        update_fifo();
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE); end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        baud_div = 16'd3; stop2 = 1'b0;
        push(8'h55);
        tx_en = 1'b1;
        capture(42, -1, 0);
        tx_en = 1'b0;
        exp_v = wave("0101010101", 4, 1);
        checks++; if (cap_txd !== exp_v) begin errors++; $display("FAIL t1_txd got %h want %h", cap_txd, exp_v); end
        exp_v = 128'h1;
        checks++; if (cap_ren !== exp_v) begin errors++; $display("FAIL t1_r_en got %h want %h", cap_ren, exp_v); end
        exp_v = span(40, 40);
        checks++; if (cap_done !== exp_v) begin errors++; $display("FAIL t1_done got %h want %h", cap_done, exp_v); end
        exp_v = span(1, 40);
        checks++; if (cap_busy !== exp_v) begin errors++; $display("FAIL t1_busy got %h want %h", cap_busy, exp_v); end
        step();
    endtask

    task automatic test_back_to_back();
        baud_div = 16'd0; stop2 = 1'b0;
        push(8'hA3);
        push(8'h0F);
        tx_en = 1'b1;
        capture(23, -1, 0);
        tx_en = 1'b0;
        exp_v = wave("01100010110111100001", 1, 1);
        checks++; if (cap_txd !== exp_v) begin errors++; $display("FAIL t2_txd got %h want %h", cap_txd, exp_v); end
        exp_v = span(0, 0) | span(10, 10);
        checks++; if (cap_ren !== exp_v) begin errors++; $display("FAIL t2_r_en got %h want %h", cap_ren, exp_v); end
        exp_v = span(10, 10) | span(20, 20);
        checks++; if (cap_done !== exp_v) begin errors++; $display("FAIL t2_done got %h want %h", cap_done, exp_v); end
        exp_v = span(1, 20);
        checks++; if (cap_busy !== exp_v) begin errors++; $display("FAIL t2_busy got %h want %h", cap_busy, exp_v); end
        step();
    endtask

    task automatic test_stop2();
        baud_div = 16'd1; stop2 = 1'b1;
        push(8'hFF);
        tx_en = 1'b1;
        // settings changed mid-frame must not affect this frame
        capture(25, 6, 2);
        tx_en = 1'b0;
        exp_v = wave("01111111111", 2, 1);
        checks++; if (cap_txd !== exp_v) begin errors++; $display("FAIL t3_txd got %h want %h", cap_txd, exp_v); end
        exp_v = span(22, 22);
        checks++; if (cap_done !== exp_v) begin errors++; $display("FAIL t3_done got %h want %h", cap_done, exp_v); end
        exp_v = span(1, 22);
        checks++; if (cap_busy !== exp_v) begin errors++; $display("FAIL t3_busy got %h want %h", cap_busy, exp_v); end
        step();
    endtask

    task automatic test_tx_en_drop();
        baud_div = 16'd1; stop2 = 1'b0;
        push(8'h3C);
        push(8'h5A);
        tx_en = 1'b1;
        capture(40, 8, 1);
        exp_v = wave("0001111001", 2, 1);
        checks++; if (cap_txd !== exp_v) begin errors++; $display("FAIL t4_txd got %h want %h", cap_txd, exp_v); end
        exp_v = 128'h1;
        checks++; if (cap_ren !== exp_v) begin errors++; $display("FAIL t4_r_en got %h want %h", cap_ren, exp_v); end
        exp_v = span(20, 20);
        checks++; if (cap_done !== exp_v) begin errors++; $display("FAIL t4_done got %h want %h", cap_done, exp_v); end
        exp_v = span(1, 20);
        checks++; if (cap_busy !== exp_v) begin errors++; $display("FAIL t4_busy got %h want %h", cap_busy, exp_v); end
        checks++; if (fifo_q.size() != 1) begin errors++; $display("FAIL t4_fifo_left got %0d want 1", fifo_q.size()); end
        fifo_q.delete();
        update_fifo();
        step();
    endtask

    task automatic test_reset_mid_frame();
        baud_div = 16'd3; stop2 = 1'b0;
        push(8'h81);
        push(8'h42);
        tx_en = 1'b1;
        capture(14, -1, 0);
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL t5_rst_txd got %b want 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_rst_busy got %b want 0", busy); end
        checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL t5_rst_r_en got %b want 0", fifo_r_en); end
        checks++; if (fifo_q.size() != 1) begin errors++; $display("FAIL t5_fifo_left got %0d want 1", fifo_q.size()); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++; if (fifo_r_en !== 1'b1) begin errors++; $display("FAIL t5_release_r_en got %b want 1", fifo_r_en); end
        capture(42, -1, 0);
        tx_en = 1'b0;
        exp_v = wave("0010000101", 4, 1);
        checks++; if (cap_txd !== exp_v) begin errors++; $display("FAIL t5_txd got %h want %h", cap_txd, exp_v); end
        exp_v = 128'h1;
        checks++; if (cap_ren !== exp_v) begin errors++; $display("FAIL t5_r_en got %h want %h", cap_ren, exp_v); end
        step();
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        baud_div = 16'd2; stop2 = 1'b0; parity_en = 1'b1; parity_odd = 1'b0;
        push(8'h07);
        tx_en = 1'b1;
        capture(35, -1, 0);
        tx_en = 1'b0;
        exp_v = wave("01110000011", 3, 1);
        checks++; if (cap_txd !== exp_v) begin errors++; $display("FAIL t6_even_txd got %h want %h", cap_txd, exp_v); end
        exp_v = span(33, 33);
        checks++; if (cap_done !== exp_v) begin errors++; $display("FAIL t6_even_done got %h want %h", cap_done, exp_v); end
        step();
        parity_odd = 1'b1;
        push(8'h07);
        tx_en = 1'b1;
        capture(35, -1, 0);
        tx_en = 1'b0;
        exp_v = wave("01110000001", 3, 1);
        checks++; if (cap_txd !== exp_v) begin errors++; $display("FAIL t6_odd_txd got %h want %h", cap_txd, exp_v); end
        exp_v = span(33, 33);
        checks++; if (cap_done !== exp_v) begin errors++; $display("FAIL t6_odd_done got %h want %h", cap_done, exp_v); end
        parity_en = 1'b0;
        step();
    endtask
`endif

    initial begin
        pop_pending = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stop2();
        test_tx_en_drop();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
